// File: rtl/bullet_pkg.sv
// bullet_pkg: shared constants and helpers for the projectile pool.
//   POS_W/X_W/Y_W  - packed position layout {X[9:0], Y[8:0]}
//   DEAD_POSITION  - position reported by a free slot
//   DISP_W/DISP_H  - default display geometry
//   packPos/posX/posY - pack and unpack a position word
package bullet_pkg;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int POS_W = X_W + Y_W;

    localparam logic [POS_W-1:0] DEAD_POSITION = 19'h7FFFF;

    localparam int DISP_W = 640;
    localparam int DISP_H = 480;

    function automatic logic [POS_W-1:0] packPos(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

    function automatic logic [X_W-1:0] posX(input logic [POS_W-1:0] pos);
        return pos[POS_W-1:Y_W];
    endfunction

    function automatic logic [Y_W-1:0] posY(input logic [POS_W-1:0] pos);
        return pos[Y_W-1:0];
    endfunction
endpackage

// File: rtl/bullet_slot_alloc.sv
// bullet_slot_alloc: lowest-index-first priority encoder over a free vector.
//   i_FreeVec  - one bit per slot, 1 = slot is free
//   o_Grant    - one-hot grant of the lowest free slot (all zero if none)
//   o_fAnyFree - at least one slot is free
module bullet_slot_alloc #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_FreeVec,
    output logic [N-1:0] o_Grant,
    output logic         o_fAnyFree
);
    // x & -x isolates the lowest set bit.
    assign o_Grant    = i_FreeVec & (~i_FreeVec + 1'b1);
    assign o_fAnyFree = |i_FreeVec;
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: reusable pool of N_SLOT projectiles.
//   i_Clk, i_Rst     - clock, synchronous active-low reset
//   i_fTick          - frame tick; movement and cooldown advance on it
//   i_fSpawn         - spawn request, taken when o_fSpawnReady is high
//   i_SpawnPos/Dir   - spawn position {X,Y} and direction (1 = up)
//   o_fSpawnReady    - cooldown expired and a slot is free
//   i_KillMask       - per-slot kill from the collision checker
//   o_BulletState    - per-slot alive flags
//   o_BulletPos      - packed positions, slot k at [19k+18:19k]
//   o_ActiveCnt      - number of alive slots
module bullet_pool #(
    parameter int N_SLOT   = 16,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 11,
    parameter int BULLET_H = 20,
    parameter int DISP_W   = bullet_pkg::DISP_W,
    parameter int DISP_H   = bullet_pkg::DISP_H
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst,
    input  logic                              i_fTick,
    input  logic                              i_fSpawn,
    input  logic [bullet_pkg::POS_W-1:0]      i_SpawnPos,
    input  logic                              i_SpawnDir,
    output logic                              o_fSpawnReady,
    input  logic [N_SLOT-1:0]                 i_KillMask,
    output logic [N_SLOT-1:0]                 o_BulletState,
    output logic [N_SLOT*bullet_pkg::POS_W-1:0] o_BulletPos,
    output logic [5:0]                        o_ActiveCnt
);
    import bullet_pkg::*;

    if (N_SLOT < 2 || N_SLOT > 32) begin : gBadSlot
        $error("bullet_pool: N_SLOT out of range");
    end
    if (SPEED < 1 || SPEED > 15) begin : gBadSpeed
        $error("bullet_pool: SPEED out of range");
    end
    if (DISP_W > (1 << X_W) || DISP_H > (1 << Y_W)) begin : gBadDisp
        $error("bullet_pool: display does not fit position fields");
    end

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [X_W-1:0]  SPD     = X_W'(SPEED);
    // Lowest Y a down-moving bullet may still occupy.
    localparam logic [X_W-1:0]  Y_LIMIT = X_W'(DISP_H - BULLET_H);

    logic [N_SLOT-1:0]            stateQ, stateN;
    logic [N_SLOT-1:0]            dirQ, dirN;
    logic [N_SLOT-1:0][POS_W-1:0] posQ, posN;
    logic [CD_W-1:0]              cdQ, cdN;
    logic [5:0]                   cntQ, cntN;

    logic [N_SLOT-1:0] grant;
    logic              fAnyFree;
    logic              fAccept;

    bullet_slot_alloc #(.N(N_SLOT)) uAlloc (
        .i_FreeVec  (~stateQ),
        .o_Grant    (grant),
        .o_fAnyFree (fAnyFree)
    );

    assign o_fSpawnReady = (cdQ == '0) && fAnyFree;
    assign fAccept       = i_fSpawn && o_fSpawnReady;

    always_comb begin
        logic [X_W-1:0] y10;
        stateN = stateQ;
        dirN   = dirQ;
        posN   = posQ;
        cntN   = '0;
        y10    = '0;
        for (int k = 0; k < N_SLOT; k++) begin
            // Y widened to 10 bits so the border compares cannot wrap.
            y10 = {1'b0, posY(posQ[k])};
            if (i_KillMask[k] && stateQ[k]) begin
                stateN[k] = 1'b0;
                posN[k]   = DEAD_POSITION;
            end else if (fAccept && grant[k]) begin
                // A freshly spawned bullet stays put even on a tick edge.
                stateN[k] = 1'b1;
                posN[k]   = i_SpawnPos;
                dirN[k]   = i_SpawnDir;
            end else if (i_fTick && stateQ[k]) begin
                if (dirQ[k]) begin
                    if (y10 < SPD) begin
                        stateN[k] = 1'b0;
                        posN[k]   = DEAD_POSITION;
                    end else begin
                        posN[k] = packPos(posX(posQ[k]), Y_W'(y10 - SPD));
                    end
                end else begin
                    if (y10 + SPD > Y_LIMIT) begin
                        stateN[k] = 1'b0;
                        posN[k]   = DEAD_POSITION;
                    end else begin
                        posN[k] = packPos(posX(posQ[k]), Y_W'(y10 + SPD));
                    end
                end
            end
            cntN = cntN + 6'(stateN[k]);
        end
    end

    always_comb begin
        cdN = cdQ;
        if (fAccept)
            cdN = CD_LOAD;
        else if (i_fTick && cdQ != '0)
            cdN = cdQ - 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            stateQ <= '0;
            dirQ   <= '0;
            posQ   <= {N_SLOT{DEAD_POSITION}};
            cdQ    <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateN;
            dirQ   <= dirN;
            posQ   <= posN;
            cdQ    <= cdN;
            cntQ   <= cntN;
        end
    end

    assign o_BulletState = stateQ;
    assign o_BulletPos   = posQ;
    assign o_ActiveCnt   = cntQ;
endmodule
